// File: rtl/mem_key_controller.sv
// ----------------------------------------------------------------------------
// mem_key_controller
//
// Drives a 16x8 synchronous RAM from four active-low pushbuttons. KEY[0] and
// KEY[1] step the address down and up. KEY[2] and KEY[3] decrement and
// increment the byte at the current address using a read-modify-write.
//
// Ports:
//   clk    in   1    system clock, all state changes on posedge
//   rst_n  in   1    asynchronous active-low reset
//   KEY    in   4    raw pushbuttons, asynchronous, 0 = pressed
//   dout   in   DW   RAM read data (registered, 1-cycle latency from a)
//   a      out  AW   RAM address
//   din    out  DW   RAM write data
//   we     out  1    RAM write enable, one-cycle pulse per data key press
//
// Handshake: there is no valid/ready pair. A press event is a single-cycle
// pulse that is either consumed in IDLE or dropped; it is never queued.
// ----------------------------------------------------------------------------
module mem_key_controller #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AW              = 4,
    parameter int DW              = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    KEY,
    input  logic [DW-1:0] dout,
    output logic [AW-1:0] a,
    output logic [DW-1:0] din,
    output logic          we
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The debounced state flips on the cycle the count would reach
    // DEBOUNCE_CYCLES, so the compare is against one less.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    // Input path state
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    press;

    // FSM and output registers
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] din_q, din_d;
    logic          we_q, we_d;

    // Debounce: the counter runs only while the synchronised key disagrees
    // with the accepted state, so any bounce back to agreement restarts it.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Press event is the debounced 1->0 edge, seen in the cycle it commits.
    assign press = deb_q & ~deb_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        din_d   = din_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    a_d     = a_q - AW'(1);
                    state_d = S_SETTLE;
                end else if (press[1]) begin
                    a_d     = a_q + AW'(1);
                    state_d = S_SETTLE;
                end else if (press[2]) begin
                    din_d   = dout - DW'(1);
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end else if (press[3]) begin
                    din_d   = dout + DW'(1);
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_SETTLE;
            end
            // SETTLE lets the RAM's registered read catch up with the new
            // address or with the byte just written before IDLE trusts dout.
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            deb_q   <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= S_IDLE;
            a_q     <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            a_q     <= a_d;
            din_q   <= din_d;
            we_q    <= we_d;
        end
    end

    assign a   = a_q;
    assign din = din_q;
    assign we  = we_q;

endmodule

// File: tb/tb_mem_key_controller.sv
// ----------------------------------------------------------------------------
// tb_mem_key_controller
//
// Bench for mem_key_controller with DEBOUNCE_CYCLES=4. Holds a 16x8 RAM with
// old-data read-during-write semantics, and a reference model made of an
// expected address, expected write data, expected byte array and expected
// write-pulse count, updated once per accepted key press.
// ----------------------------------------------------------------------------
module tb_mem_key_controller;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    KEY;
    logic [DW-1:0] dout;
    logic [AW-1:0] a;
    logic [DW-1:0] din;
    logic          we;

    mem_key_controller #(
        .DEBOUNCE_CYCLES(4),
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .KEY  (KEY),
        .dout (dout),
        .a    (a),
        .din  (din),
        .we   (we)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [DW-1:0] mem [16];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (we) mem[a] <= din;
        dout <= mem[a];
    end

    int we_cnt = 0;
    always @(posedge clk) begin
        if (rst_n && we) we_cnt <= we_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_mem [16];
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_din;
    int            exp_we;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted press: the lowest-numbered key wins, everything else in the
    // mask is ignored.
    task automatic model_press(input logic [3:0] mask);
        if (mask[0]) begin
            exp_a = exp_a - 1;
        end else if (mask[1]) begin
            exp_a = exp_a + 1;
        end else if (mask[2]) begin
            exp_mem[exp_a] = exp_mem[exp_a] - 1;
            exp_din = exp_mem[exp_a];
            exp_we++;
        end else if (mask[3]) begin
            exp_mem[exp_a] = exp_mem[exp_a] + 1;
            exp_din = exp_mem[exp_a];
            exp_we++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"},    32'(a),      32'(exp_a));
        check({tag, ".din"},  32'(din),    32'(exp_din));
        check({tag, ".dout"}, 32'(dout),   32'(exp_mem[exp_a]));
        check({tag, ".we"},   32'(we_cnt), 32'(exp_we));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic poke(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        exp_mem[addr] = data;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Hold the keys in mask low for hold cycles, then release for long enough
    // that the release debounces and the FSM is back in IDLE.
    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        KEY = ~mask;
        wait_cycles(hold);
        KEY = 4'hF;
        wait_cycles(12);
    endtask

    // Too short to survive the debouncer.
    task automatic bounce(input int k, input int len);
        @(negedge clk);
        KEY[k] = 1'b0;
        wait_cycles(len);
        KEY = 4'hF;
        wait_cycles(12);
    endtask

    // Second key arrives off cycles after the first, landing in WRITE/SETTLE.
    task automatic stagger(input int k1, input int k2, input int off);
        @(negedge clk);
        KEY[k1] = 1'b0;
        wait_cycles(off);
        KEY[k2] = 1'b0;
        wait_cycles(12);
        KEY = 4'hF;
        wait_cycles(12);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        KEY   = 4'hF;
        wait_cycles(3);
        rst_n = 1'b1;
        exp_a   = '0;
        exp_din = '0;
        wait_cycles(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] m;
        int         r, k, k2;
        bit         seen;

        rst_n  = 1'b0;
        KEY    = 4'hF;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        exp_a = '0;
        exp_din = '0;
        exp_we = 0;

        // Preload the RAM while reset is held.
        for (int i = 0; i < 16; i++) poke(AW'(i), DW'($urandom_range(0, 255)));
        poke(4'h0, 8'hFF);
        poke(4'h5, 8'h05);

        @(negedge clk);
        check("reset.a",   32'(a),   32'h0);
        check("reset.din", 32'(din), 32'h0);
        check("reset.we",  32'(we),  32'h0);

        rst_n = 1'b1;
        wait_cycles(20);
        check("idle.no_we", 32'(we_cnt), 32'h0);
        check_all("idle");

        // Held key gives exactly one event, with 0xFF+1 wrapping to 0x00.
        press(4'b1000, 50);
        model_press(4'b1000);
        check_all("hold_inc");
        check("hold_inc.mem0", 32'(mem[0]), 32'h00);

        // Address wraps both ways.
        press(4'b0001, 10);
        model_press(4'b0001);
        check_all("addr_dec_wrap");
        check("addr_dec_wrap.aF", 32'(a), 32'hF);
        press(4'b0010, 10);
        model_press(4'b0010);
        check_all("addr_inc_wrap");

        // Short bounce is rejected, a longer hold is accepted.
        bounce(2, 3);
        check_all("bounce3");
        press(4'b0100, 10);
        model_press(4'b0100);
        check_all("dec_after_bounce");

        // Simultaneous KEY[1] and KEY[3]: only the address moves.
        press(4'b1010, 10);
        model_press(4'b1010);
        check_all("simul_1_3");

        // Events arriving during WRITE and SETTLE are discarded.
        stagger(3, 1, 1);
        model_press(4'b1000);
        check_all("stagger_write");
        stagger(2, 0, 2);
        model_press(4'b0100);
        check_all("stagger_settle");

        // Randomised mix of presses, combos, bounces and late arrivals.
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                k = $urandom_range(0, 3);
                m = 4'b0001 << k;
                press(m, $urandom_range(8, 30));
                model_press(m);
            end else if (r <= 7) begin
                m = 4'($urandom_range(1, 15));
                press(m, $urandom_range(8, 30));
                model_press(m);
            end else if (r == 8) begin
                bounce($urandom_range(0, 3), $urandom_range(1, 3));
            end else begin
                k  = $urandom_range(2, 3);
                k2 = $urandom_range(0, 3);
                if (k2 == k) k2 = 0;
                stagger(k, k2, $urandom_range(1, 2));
                m = 4'b0001 << k;
                model_press(m);
            end
            check_all($sformatf("rand%0d", it));
        end

        // a=5 with mem[5]=0x05, two decrements, then reset mid-write.
        do_reset();
        check("reset2.a", 32'(a), 32'h0);
        poke(4'h5, 8'h05);
        for (int i = 0; i < 5; i++) begin
            press(4'b0010, 10);
            model_press(4'b0010);
        end
        press(4'b0100, 10);
        model_press(4'b0100);
        press(4'b0100, 10);
        model_press(4'b0100);
        check_all("mem5_dec2");
        check("mem5_dec2.val", 32'(dout), 32'h03);

        @(negedge clk);
        KEY[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (we) seen = 1'b1;
        end
        check("midwrite.we_seen", 32'(seen), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midwrite.we", 32'(we), 32'h0);
        check("midwrite.a",  32'(a),  32'h0);
        KEY = 4'hF;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
